pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order pipeline. It replaces the fixed two-stage forwarding unit and single-cycle load-use detector with one block. The block tracks in-flight register writers over DEPTH post-decode stages and checks NUM_SRC source operands of the instruction in ID. It issues registered forward selects for EX and combinational stall/bubble controls, and supports multi-cycle load latency, flush and external freeze.

Parameters:
NUM_SRC, 2, source operands checked per ID instruction
REG_AW, 5, register address width
DEPTH, 3, tracked stages after ID (stage 1 = EX ... stage DEPTH = WB); minimum 2
LOAD_STAGE, 2, stage at whose end load data becomes forwardable (2 = MEM); range 1..DEPTH-1

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
id_valid_i  in  1  valid instruction in ID
id_src_addr_i  in  NUM_SRC*REG_AW  source register addresses, operand j at [j*REG_AW +: REG_AW]
id_src_used_i  in  NUM_SRC  operand j actually read
id_rd_i  in  REG_AW  destination register of ID instruction
id_regwrite_i  in  1  ID instruction writes rd
id_is_load_i  in  1  ID instruction is a load
flush_i  in  1  kill ID instruction (taken branch/jump)
ext_stall_i  in  1  freeze entire pipeline (memory wait)
fwd_sel_o  out  NUM_SRC*SW  registered forward select per operand, SW = $clog2(DEPTH)
stall_o  out  1  load-use stall this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register enable
bubble_o  out  1  ID/EX control zeroed this cycle
stall_cnt_o  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Reset: all tracker entries invalid; fwd_sel_o = 0; stall_cnt_o = 0. Asynchronous assert, synchronous deassert handled upstream.
- Tracker: DEPTH entries {valid, rd, regwrite, is_load}.
- Match for operand j at stage k (1..DEPTH-1): used[j] & addr != 0 & valid & regwrite & rd == addr. Stage DEPTH is never matched. It commits this cycle, and the register file is write-first.
- Youngest match wins: lowest k.
- No match -> next sel 0 (register file).
- Match at k with is_load & k < LOAD_STAGE -> hazard for that operand.
- Otherwise next sel = k. Value k means that, when the consumer is in EX, it takes the result register at the output of stage k (1 = EX/MEM, 2 = MEM/WB, ...).
- hazard = OR of operand hazards.
- stall_o = id_valid_i & hazard & ~flush_i.
- issue = id_valid_i & ~stall_o & ~flush_i.
- bubble_o = ~issue.
- pc_write_o = ifid_write_o = ~stall_o & ~ext_stall_i.
- Clock edge with ext_stall_i = 0:
  - entry[1] <= issue ? {1, id_rd_i, id_regwrite_i, id_is_load_i} : invalid;
  - entry[k] <= entry[k-1];
  - fwd_sel_o <= issue ? computed sels : 0.
- Clock edge with ext_stall_i = 1: entries and fwd_sel_o hold. stall_o is still reported, but no bubble is inserted into the tracker.
- Multi-cycle loads: stall repeats each cycle while the producer sits at a stage below LOAD_STAGE. The stall length for a dependent instruction right after a load is LOAD_STAGE-1 cycles.
- flush_i together with hazard: flush wins; no stall, PC redirects, bubble inserted.
- Reset asserted mid-operation: all in-flight entries are dropped immediately; outputs return to reset values.

Optional Feature:
HAZ_PERF_EN
- Defined: stall_cnt_o increments on each clock edge where stall_o & ~ext_stall_i. It saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg:
  - inflight_entry_t struct (valid, rd, regwrite, is_load);
  - REG_ZERO constant;
  - SEL_REGFILE = 0 constant.
- Sub-module hazard_src_match, instantiated NUM_SRC times. It takes the entry vector and one operand and returns {hazard, sel}. It is a purely combinational priority search.
- The tracker shift register and counter stay in the top.

Test Plan:
- Defaults. add r3 issued, next cycle instruction reads r3 as src0 -> no stall; fwd_sel_o[src0] = 1 when consumer in EX.
- lw r4 then add using r4 -> stall_o = 1 for 1 cycle, pc_write_o = ifid_write_o = 0, bubble_o = 1; next cycle fwd_sel = 2.
- DEPTH=4, LOAD_STAGE=3: lw r5 then use r5 -> exactly 2 stall cycles, then fwd_sel = 3.
- Writer to r0 followed by r0 reader -> sel 0, never stall. Two writers of r6 at stages 1 and 2 -> sel 1 (youngest).
- Load-use hazard with flush_i = 1 -> stall_o = 0, bubble_o = 1, entry[1] invalid. ext_stall_i held 3 cycles -> entries and fwd_sel_o unchanged.
- Reset pulse while load in flight -> entries cleared, stall_o = 0 next cycle. With HAZ_PERF_EN, 5 load-use stalls -> stall_cnt_o = 5, and the counter is 0 after reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Widest register address the tracker can hold; narrower addresses are zero-extended.
  localparam int MAX_REG_AW = 8;

  localparam logic [MAX_REG_AW-1:0] REG_ZERO    = '0;
  localparam int                    SEL_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } inflight_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// Priority search of the in-flight writers for one ID source operand.
// Returns a load-use hazard flag and the forward select for the youngest match.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = 2
) (
  input  inflight_entry_t [DEPTH-1:0] i_entries,
  input  logic [REG_AW-1:0]           i_addr,
  input  logic                        i_used,
  output logic                        o_hazard,
  output logic [SW-1:0]               o_sel
);

  logic [MAX_REG_AW-1:0] w_addr;
  logic                  w_found;

  assign w_addr = MAX_REG_AW'(i_addr);

  // Index k holds stage k+1; the last stage commits this cycle and is never matched.
  always_comb begin
    o_hazard = 1'b0;
    o_sel    = SW'(SEL_REGFILE);
    w_found  = 1'b0;
    for (int k = 0; k < DEPTH-1; k++) begin
      if (!w_found && i_used && (w_addr != REG_ZERO) && i_entries[k].valid &&
          i_entries[k].regwrite && (i_entries[k].rd == w_addr)) begin
        w_found = 1'b1;
        if (i_entries[k].is_load && (k + 1 < LOAD_STAGE))
          o_hazard = 1'b1;
        else
          o_sel = SW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks DEPTH post-decode writers, raises load-use stalls,
// registers forward selects for EX. Define HAZ_PERF_EN to get a saturating stall counter.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int REG_AW     = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 2,
  localparam int SW         = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_is_load_i,
  input  logic                      flush_i,
  input  logic                      ext_stall_i,
  output logic [NUM_SRC*SW-1:0]     fwd_sel_o,
  output logic                      stall_o,
  output logic                      pc_write_o,
  output logic                      ifid_write_o,
  output logic                      bubble_o,
  output logic [31:0]               stall_cnt_o
);

  inflight_entry_t [DEPTH-1:0] r_entries;
  logic [NUM_SRC*SW-1:0]       r_fwd_sel;
  logic [NUM_SRC-1:0]          w_haz;
  logic [NUM_SRC*SW-1:0]       w_sel;
  logic                        w_stall;
  logic                        w_issue;
  inflight_entry_t             w_new;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    hazard_src_match #(
      .REG_AW    (REG_AW),
      .DEPTH     (DEPTH),
      .LOAD_STAGE(LOAD_STAGE),
      .SW        (SW)
    ) u_match (
      .i_entries(r_entries),
      .i_addr   (id_src_addr_i[j*REG_AW +: REG_AW]),
      .i_used   (id_src_used_i[j]),
      .o_hazard (w_haz[j]),
      .o_sel    (w_sel[j*SW +: SW])
    );
  end

  // Flush overrides a hazard: the killed instruction must not hold the front end.
  assign w_stall      = id_valid_i & (|w_haz) & ~flush_i;
  assign w_issue      = id_valid_i & ~w_stall & ~flush_i;
  assign stall_o      = w_stall;
  assign bubble_o     = ~w_issue;
  assign pc_write_o   = ~w_stall & ~ext_stall_i;
  assign ifid_write_o = ~w_stall & ~ext_stall_i;
  assign fwd_sel_o    = r_fwd_sel;

  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.rd       = MAX_REG_AW'(id_rd_i);
    w_new.regwrite = id_regwrite_i;
    w_new.is_load  = id_is_load_i;
  end

  // External freeze holds the whole tracker; otherwise shift, inserting a bubble when not issuing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_entries <= '0;
      r_fwd_sel <= '0;
    end else if (!ext_stall_i) begin
      r_entries <= {r_entries[DEPTH-2:0], (w_issue ? w_new : inflight_entry_t'('0))};
      r_fwd_sel <= w_issue ? w_sel : '0;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_stall_cnt <= '0;
    else if (w_stall && !ext_stall_i && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build plus a DEPTH=4/LOAD_STAGE=3 instance.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [4:0]  rd;
  logic        regwrite;
  logic        is_load;
  logic        flush;
  logic        ext_stall;

  logic [3:0]  a_sel, b_sel;
  logic        a_stall, a_pc, a_ifid, a_bubble;
  logic        b_stall, b_pc, b_ifid, b_bubble;
  logic [31:0] a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  pipe_hazard_ctrl u_a (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_src_addr_i(src_addr),
    .id_src_used_i(src_used), .id_rd_i(rd), .id_regwrite_i(regwrite), .id_is_load_i(is_load),
    .flush_i(flush), .ext_stall_i(ext_stall), .fwd_sel_o(a_sel), .stall_o(a_stall),
    .pc_write_o(a_pc), .ifid_write_o(a_ifid), .bubble_o(a_bubble), .stall_cnt_o(a_cnt)
  );

  pipe_hazard_ctrl #(.DEPTH(4), .LOAD_STAGE(3)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_src_addr_i(src_addr),
    .id_src_used_i(src_used), .id_rd_i(rd), .id_regwrite_i(regwrite), .id_is_load_i(is_load),
    .flush_i(flush), .ext_stall_i(ext_stall), .fwd_sel_o(b_sel), .stall_o(b_stall),
    .pc_write_o(b_pc), .ifid_write_o(b_ifid), .bubble_o(b_bubble), .stall_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] used, input logic [4:0] d, input logic rw,
                       input logic ld);
    id_valid = v;
    src_addr = {s1, s0};
    src_used = used;
    rd       = d;
    regwrite = rw;
    is_load  = ld;
  endtask

  initial begin
`ifdef HAZ_PERF_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    rst_n = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    #2;
    chk("rst_sel", 32'(a_sel), 32'h0);
    chk("rst_stall", 32'(a_stall), 32'h0);
    chk("rst_bubble", 32'(a_bubble), 32'h1);
    chk("rst_cnt", a_cnt, 32'h0);
    tick();
    rst_n = 1'b1;

    // ALU producer then consumer: forward from EX/MEM
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); #2;
    chk("alu_prod_stall", 32'(a_stall), 32'h0);
    chk("alu_prod_bubble", 32'(a_bubble), 32'h0);
    tick();
    instr(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0); #2;
    chk("alu_use_stall", 32'(a_stall), 32'h0);
    tick();

    // load-use: one stall, then forward from MEM/WB on both operands
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1); #2;
    chk("alu_fwd_sel1", 32'(a_sel), 32'h1);
    tick();
    instr(1'b1, 5'd4, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0); #2;
    chk("lu_stall", 32'(a_stall), 32'h1);
    chk("lu_pc", 32'(a_pc), 32'h0);
    chk("lu_ifid", 32'(a_ifid), 32'h0);
    chk("lu_bubble", 32'(a_bubble), 32'h1);
    tick(); #2;
    chk("lu_stall_end", 32'(a_stall), 32'h0);
    chk("lu_bubble_end", 32'(a_bubble), 32'h0);
    tick();

    // r0 writer (a load) must never cause a stall or a forward
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1); #2;
    chk("lu_fwd_sel2", 32'(a_sel), 32'hA);
    tick();
    instr(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0); #2;
    chk("r0_stall", 32'(a_stall), 32'h0);
    tick();

    // two writers of r6: youngest (stage 1) wins
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0); #2;
    chk("r0_sel", 32'(a_sel), 32'h0);
    tick();
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
    tick();
    instr(1'b1, 5'd6, 5'd0, 2'b10, 5'd0, 1'b0, 1'b0);
    tick();

    // flush wins over load-use; flushed writer of r8 must not enter the tracker
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1); #2;
    chk("youngest_sel", 32'(a_sel), 32'h4);
    tick();
    instr(1'b1, 5'd0, 5'd7, 2'b01, 5'd8, 1'b1, 1'b0);
    flush = 1'b1; #2;
    chk("flush_stall", 32'(a_stall), 32'h0);
    chk("flush_bubble", 32'(a_bubble), 32'h1);
    chk("flush_pc", 32'(a_pc), 32'h1);
    tick();
    flush = 1'b0;
    instr(1'b1, 5'd8, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0); #2;
    chk("post_flush_stall", 32'(a_stall), 32'h0);
    tick();

    // external freeze: selects and tracker hold for 3 cycles
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0); #2;
    chk("post_flush_sel", 32'(a_sel), 32'h2);
    tick();
    instr(1'b1, 5'd0, 5'd9, 2'b01, 5'd10, 1'b1, 1'b0);
    tick();
    instr(1'b1, 5'd9, 5'd10, 2'b11, 5'd0, 1'b0, 1'b0);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("frz_sel", 32'(a_sel), 32'h1);
      chk("frz_pc", 32'(a_pc), 32'h0);
      chk("frz_stall", 32'(a_stall), 32'h0);
      tick();
    end
    ext_stall = 1'b0; #2;
    chk("unfrz_pc", 32'(a_pc), 32'h1);
    tick();

    // load-use under freeze: stall reported, not counted
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1); #2;
    chk("unfrz_sel", 32'(a_sel), 32'h9);
    tick();
    instr(1'b1, 5'd0, 5'd11, 2'b01, 5'd0, 1'b0, 1'b0);
    ext_stall = 1'b1; #2;
    chk("frz_lu_stall", 32'(a_stall), 32'h1);
    chk("frz_lu_bubble", 32'(a_bubble), 32'h1);
    tick();
    ext_stall = 1'b0; #2;
    chk("frz_lu_stall2", 32'(a_stall), 32'h1);
    tick(); #2;
    chk("frz_lu_done", 32'(a_stall), 32'h0);
    tick();

    for (int i = 0; i < 3; i++) begin
      instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b1);
      tick();
      instr(1'b1, 5'd12, 5'd0, 2'b10, 5'd0, 1'b0, 1'b0); #2;
      chk("loop_stall", 32'(a_stall), 32'h1);
      tick(); #2;
      chk("loop_nostall", 32'(a_stall), 32'h0);
      tick();
    end
    instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0); #2;
    chk("stall_cnt", a_cnt, exp_cnt);
    tick();

    // asynchronous reset with a load in flight
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b1);
    tick();
    instr(1'b1, 5'd0, 5'd13, 2'b01, 5'd0, 1'b0, 1'b0); #2;
    chk("pre_rst_stall", 32'(a_stall), 32'h1);
    rst_n = 1'b0; #1;
    chk("mid_rst_stall", 32'(a_stall), 32'h0);
    chk("mid_rst_sel", 32'(a_sel), 32'h0);
    chk("mid_rst_cnt", a_cnt, 32'h0);
    tick();
    rst_n = 1'b1; #2;
    chk("post_rst_stall", 32'(a_stall), 32'h0);
    tick();

    // DEPTH=4, LOAD_STAGE=3: two stall cycles then forward from stage 3
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    instr(1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 1'b0); #2;
    chk("d4_stall1", 32'(b_stall), 32'h1);
    tick(); #2;
    chk("d4_stall2", 32'(b_stall), 32'h1);
    tick(); #2;
    chk("d4_stall3", 32'(b_stall), 32'h0);
    tick();
    instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0); #2;
    chk("d4_sel", 32'(b_sel), 32'h3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
